// File: rtl/product_bcd_display.sv
// ---------------------------------------------------------------------------
// product_bcd_display
//   Captures the 8-bit product of the 4x4 shift-add multiplier, converts it to
//   three BCD digits with a sequential double-dabble (8 cycles), and scans
//   the digits onto a multiplexed 3-digit common-anode 7-segment display.
//
// Parameters
//   SCAN_DIV  clk cycles each digit stays enabled before the scan advances (>=2)
//   BLANK_LZ  1: blank leading zeros (hundreds if 0; tens if hundreds and tens 0)
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   p_in       in   8   unsigned product, sampled only at the accept edge
//   load       in   1   conversion request
//   busy       out  1   conversion in progress
//   done       out  1   one-cycle pulse: bcd/display just took a new value
//   bcd        out  12  {hundreds,tens,units} of the last completed conversion
//   seg        out  7   active-low segments {a,b,c,d,e,f,g} of the enabled digit
//   an         out  3   active-low one-hot digit enable, an[0]=units
//   dbg_state  out  1   FSM state (0=IDLE, 1=CONV)
//
// Handshake: load is a request and ~busy is its ready. A request is accepted
// on a rising edge where load=1 and busy=0; requests while busy are dropped,
// not queued. done is a one-cycle pulse with no backpressure; load may be
// accepted in the same cycle done is high.
// ---------------------------------------------------------------------------
module product_bcd_display #(
    parameter int SCAN_DIV = 1000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  p_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        dbg_state
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [19:0]   sh, sh_nxt, sh_adj;     // {hundreds,tens,units,binary}
    logic [2:0]    bitcnt, bitcnt_nxt;
    logic          done_nxt;
    logic [11:0]   bcd_nxt;

    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    seg_nxt;
    logic [2:0]    an_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Double-dabble correction: +3 on every BCD nibble >= 5 before the shift.
    always_comb begin
        sh_adj = sh;
        for (int i = 0; i < 3; i++) begin
            if (sh[8+4*i +: 4] >= 4'd5)
                sh_adj[8+4*i +: 4] = sh[8+4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nxt  = state;
        sh_nxt     = sh;
        bitcnt_nxt = bitcnt;
        done_nxt   = 1'b0;
        bcd_nxt    = bcd;
        case (state)
            IDLE: begin
                if (load) begin
                    sh_nxt     = {12'd0, p_in};
                    bitcnt_nxt = 3'd0;
                    state_nxt  = CONV;
                end
            end
            CONV: begin
                sh_nxt     = {sh_adj[18:0], 1'b0};
                bitcnt_nxt = bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                    // Last shift: the BCD field of the shifted value is final.
                    bcd_nxt   = sh_adj[18:7];
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Scan: free-running divider, digit index steps 0->1->2->0 at each wrap.
    always_comb begin
        cnt_nxt = cnt + 1'b1;
        idx_nxt = idx;
        if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt_nxt = '0;
            idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
    end

    // seg is computed from the next index and the next bcd so that seg and an
    // land on the same edge, and a new result shows up on the done edge.
    always_comb begin
        digit  = bcd_nxt[3:0];
        blank  = 1'b0;
        an_nxt = 3'b110;
        case (idx_nxt)
            2'd1: begin
                digit  = bcd_nxt[7:4];
                blank  = BLANK_LZ && (bcd_nxt[11:8] == 4'd0) && (bcd_nxt[7:4] == 4'd0);
                an_nxt = 3'b101;
            end
            2'd2: begin
                digit  = bcd_nxt[11:8];
                blank  = BLANK_LZ && (bcd_nxt[11:8] == 4'd0);
                an_nxt = 3'b011;
            end
            default: begin
                digit  = bcd_nxt[3:0];
                blank  = 1'b0;
                an_nxt = 3'b110;
            end
        endcase
        seg_nxt = blank ? 7'b1111111 : seg_decode(digit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sh     <= '0;
            bitcnt <= '0;
            done   <= 1'b0;
            bcd    <= 12'h000;
            cnt    <= '0;
            idx    <= 2'd0;
            an     <= 3'b110;
            seg    <= 7'b0000001;
        end else begin
            state  <= state_nxt;
            sh     <= sh_nxt;
            bitcnt <= bitcnt_nxt;
            done   <= done_nxt;
            bcd    <= bcd_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            an     <= an_nxt;
            seg    <= seg_nxt;
        end
    end

    assign busy      = (state == CONV);
    assign dbg_state = (state == CONV);

endmodule
